md_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage. It owns the HI/LO registers.
- It executes mult/multu/div/divu over a fixed latency and performs mthi/mtlo writes.
- It exports `busy` to the pipeline stall logic. That logic holds any HI/LO-dependent or md-type instruction in ID while `start || busy` is high.

---
 rtl/md_unit_if.sv | 14 +
 rtl/md_unit.sv | 137 +++++++++++++
 tb/tb_md_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// The pipeline side is the master and the md_unit side is the slave.
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, srcA, srcB, input busy, hi, lo);
  modport slave  (input start, md_op, srcA, srcB, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit that owns HI/LO.
// Operands are latched at issue, and the result commits after a fixed, parameterised latency.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic    clk,
  input logic    reset,
  md_unit_if.slave md
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  md_op_t      op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  md_op_t      op_in;
  assign op_in = md_op_t'(md.md_op);

  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  // One unsigned divider serves both div and divu. The signed form divides magnitudes and then fixes signs,
  // which also yields 0x80000000 / -1 = 0x80000000 with remainder 0.
  logic        signed_div, neg_a, neg_b;
  logic [31:0] dvd, dvs, dvs_safe, quo_mag, rem_mag, quo, rem;

  assign signed_div = (op_q == OP_DIV);
  assign neg_a      = signed_div & a_q[31];
  assign neg_b      = signed_div & b_q[31];
  assign dvd        = neg_a ? (~a_q + 32'd1) : a_q;
  assign dvs        = neg_b ? (~b_q + 32'd1) : b_q;
  assign dvs_safe   = (dvs == '0) ? 32'd1 : dvs;
  assign quo_mag    = dvd / dvs_safe;
  assign rem_mag    = dvd % dvs_safe;
  assign quo        = (neg_a ^ neg_b) ? (~quo_mag + 32'd1) : quo_mag;
  assign rem        = neg_a ? (~rem_mag + 32'd1) : rem_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      IDLE: begin
        if (md.start) begin
          unique case (op_in)
            OP_MULT, OP_MULTU: begin
              op_d    = op_in;
              a_d     = md.srcA;
              b_d     = md.srcB;
              cnt_d   = 8'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = op_in;
              a_d     = md.srcA;
              b_d     = md.srcB;
              cnt_d   = 8'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = md.srcA;
            OP_MTLO: lo_d = md.srcA;
            default: ;
          endcase
        end
      end

      RUN: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = IDLE;
          unique case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV, OP_DIVU: begin
              // A zero divisor spends the full latency but leaves HI/LO untouched.
              if (b_q != '0) begin
                hi_d = rem;
                lo_d = quo;
              end
            end
            default: ;
          endcase
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.busy = (state_q == RUN);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit that checks HI/LO and busy timing against a 64-bit arithmetic reference model.
// It drives a default-latency instance and a single-cycle instance.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;

  md_unit_if mb ();
  md_unit_if fb ();

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut_main (
    .clk   (clk),
    .reset (reset),
    .md    (mb.slave)
  );

  md_unit #(.MULT_CYCLES(1), .DIV_CYCLES(1)) dut_fast (
    .clk   (clk),
    .reset (reset),
    .md    (fb.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi, exp_lo;
  logic [31:0] fexp_hi, fexp_lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: returns {hi, lo} after an op, using 64-bit signed/unsigned arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, b, h, l);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = {h, l};
    case (op)
      3'd1: res = sa * sb;
      3'd2: res = ua * ub;
      3'd3: if (b != 0) begin
        sq  = sa / sb;
        sr  = sa % sb;
        res = {sr[31:0], sq[31:0]};
      end
      3'd4: if (b != 0) begin
        uq  = ua / ub;
        ur  = ua % ub;
        res = {ur[31:0], uq[31:0]};
      end
      3'd5: res = {a, l};
      3'd6: res = {h, a};
      default: ;
    endcase
    return res;
  endfunction

  function automatic int lat(input logic [2:0] op, input int mn, input int dn);
    if (op == 3'd1 || op == 3'd2) return mn;
    if (op == 3'd3 || op == 3'd4) return dn;
    return 0;
  endfunction

  // Issue one op on the main unit at the current negedge.
  // Operands are scrambled while the op runs. An mtlo is injected at run cycle inj (0 = never).
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, b, input int inj);
    logic [63:0] r;
    int          cyc;
    int          need;
    r    = ref_md(op, a, b, exp_hi, exp_lo);
    need = lat(op, MULT_N, DIV_N);
    mb.start = 1'b1; mb.md_op = op; mb.srcA = a; mb.srcB = b;
    @(negedge clk);
    mb.start = 1'b0;
    cyc = 0;
    while (mb.busy === 1'b1 && cyc < 300) begin
      total++;
      if (mb.hi !== exp_hi || mb.lo !== exp_lo) begin
        bad++;
        $display("FAIL %s hold: cycle %0d hi=%h lo=%h want hi=%h lo=%h", tag, cyc, mb.hi, mb.lo, exp_hi, exp_lo);
      end
      cyc++;
      mb.srcA  = $urandom;
      mb.srcB  = $urandom;
      mb.md_op = 3'($urandom_range(0, 7));
      mb.start = (cyc == inj);
      if (cyc == inj) begin
        mb.md_op = 3'd6;
        mb.srcA  = 32'hDEADBEEF;
      end
      @(negedge clk);
      mb.start = 1'b0;
    end
    total++;
    if (cyc !== need) begin
      bad++;
      $display("FAIL %s busy_len: got %0d want %0d", tag, cyc, need);
    end
    total++;
    if ({mb.hi, mb.lo} !== r) begin
      bad++;
      $display("FAIL %s result: hi=%h lo=%h want hi=%h lo=%h", tag, mb.hi, mb.lo, r[63:32], r[31:0]);
    end
    exp_hi = r[63:32];
    exp_lo = r[31:0];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (mb.busy !== 1'b0 || mb.hi !== 32'd0 || mb.lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_main: busy=%b hi=%h lo=%h want 0 0 0", mb.busy, mb.hi, mb.lo);
    end
    total++;
    if (fb.busy !== 1'b0 || fb.hi !== 32'd0 || fb.lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_fast: busy=%b hi=%h lo=%h want 0 0 0", fb.busy, fb.hi, fb.lo);
    end
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0; fexp_hi = '0; fexp_lo = '0;
  endtask

  task automatic test_mult();
    do_op("mult_neg3x5", 3'd1, 32'hFFFFFFFD, 32'd5, 0);
    total++;
    if (mb.hi !== 32'hFFFFFFFF || mb.lo !== 32'hFFFFFFF1) begin
      bad++;
      $display("FAIL mult_const: hi=%h lo=%h want FFFFFFFF FFFFFFF1", mb.hi, mb.lo);
    end
    do_op("multu_max_x2", 3'd2, 32'hFFFFFFFF, 32'd2, 0);
    total++;
    if (mb.hi !== 32'h00000001 || mb.lo !== 32'hFFFFFFFE) begin
      bad++;
      $display("FAIL multu_const: hi=%h lo=%h want 00000001 FFFFFFFE", mb.hi, mb.lo);
    end
  endtask

  task automatic test_div();
    do_op("div_neg7_2", 3'd3, 32'hFFFFFFF9, 32'd2, 0);
    total++;
    if (mb.hi !== 32'hFFFFFFFF || mb.lo !== 32'hFFFFFFFD) begin
      bad++;
      $display("FAIL div_const: hi=%h lo=%h want FFFFFFFF FFFFFFFD", mb.hi, mb.lo);
    end
    do_op("divu_7_2", 3'd4, 32'd7, 32'd2, 0);
    total++;
    if (mb.hi !== 32'd1 || mb.lo !== 32'd3) begin
      bad++;
      $display("FAIL divu_const: hi=%h lo=%h want 00000001 00000003", mb.hi, mb.lo);
    end
  endtask

  task automatic test_move_and_ignore();
    do_op("mthi", 3'd5, 32'h12345678, 32'h0, 0);
    do_op("mtlo", 3'd6, 32'h0BADF00D, 32'h0, 0);
    do_op("div_inject_mtlo", 3'd3, 32'd1000, 32'hFFFFFFF9, 4);
    do_op("mult_inject_mtlo", 3'd1, $urandom, $urandom, 2);
  endtask

  task automatic test_div_edge();
    do_op("pre_hi", 3'd5, 32'hAAAA0000, 32'h0, 0);
    do_op("pre_lo", 3'd6, 32'h0000BBBB, 32'h0, 0);
    do_op("div_by_zero", 3'd3, $urandom, 32'd0, 0);
    total++;
    if (mb.hi !== 32'hAAAA0000 || mb.lo !== 32'h0000BBBB) begin
      bad++;
      $display("FAIL div0_const: hi=%h lo=%h want AAAA0000 0000BBBB", mb.hi, mb.lo);
    end
    do_op("divu_by_zero", 3'd4, $urandom, 32'd0, 0);
    do_op("div_overflow", 3'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    total++;
    if (mb.hi !== 32'd0 || mb.lo !== 32'h80000000) begin
      bad++;
      $display("FAIL div_ovf_const: hi=%h lo=%h want 00000000 80000000", mb.hi, mb.lo);
    end
  endtask

  task automatic test_reset_mid_run();
    do_op("pre_hi2", 3'd5, 32'h11111111, 32'h0, 0);
    do_op("pre_lo2", 3'd6, 32'h22222222, 32'h0, 0);
    mb.start = 1'b1; mb.md_op = 3'd1; mb.srcA = 32'h7; mb.srcB = 32'h9;
    @(negedge clk);
    mb.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (mb.busy !== 1'b0 || mb.hi !== 32'd0 || mb.lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_run: busy=%b hi=%h lo=%h want 0 0 0", mb.busy, mb.hi, mb.lo);
    end
    exp_hi = '0; exp_lo = '0; fexp_hi = '0; fexp_lo = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (mb.busy !== 1'b0 || mb.hi !== 32'd0 || mb.lo !== 32'd0) begin
        bad++;
        $display("FAIL no_late_commit: cycle %0d busy=%b hi=%h lo=%h want 0 0 0", i, mb.busy, mb.hi, mb.lo);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      do_op("random", op, a, b, 0);
    end
  endtask

  // Single-cycle instance: each op commits one edge after issue and is re-issued right after busy falls.
  task automatic test_back_to_back();
    logic [63:0] r;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 3'(1 + (i % 4));
      a  = $urandom;
      b  = (i == 6) ? 32'd0 : $urandom;
      r  = ref_md(op, a, b, fexp_hi, fexp_lo);
      fb.start = 1'b1; fb.md_op = op; fb.srcA = a; fb.srcB = b;
      @(negedge clk);
      fb.start = 1'b0;
      fb.srcA = $urandom; fb.srcB = $urandom;
      total++;
      if (fb.busy !== 1'b1 || fb.hi !== fexp_hi || fb.lo !== fexp_lo) begin
        bad++;
        $display("FAIL fast_accept %0d: busy=%b hi=%h lo=%h want 1 %h %h", i, fb.busy, fb.hi, fb.lo, fexp_hi, fexp_lo);
      end
      @(negedge clk);
      total++;
      if (fb.busy !== 1'b0 || {fb.hi, fb.lo} !== r) begin
        bad++;
        $display("FAIL fast_commit %0d: busy=%b hi=%h lo=%h want 0 %h %h", i, fb.busy, fb.hi, fb.lo, r[63:32], r[31:0]);
      end
      fexp_hi = r[63:32];
      fexp_lo = r[31:0];
    end
  endtask

  initial begin
    reset = 1'b1;
    mb.start = 1'b0; mb.md_op = '0; mb.srcA = '0; mb.srcB = '0;
    fb.start = 1'b0; fb.md_op = '0; fb.srcA = '0; fb.srcB = '0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_move_and_ignore();
    test_div_edge();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
